// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the instruction-fetch read port and the load/store data
// port onto the single request interface of the shared memory model. A tag
// FIFO remembers which port issued each in-flight read so that the in-order
// read responses go back to the right port.
// Optional build macro: MEM_ARBITER_RR_EN selects round-robin arbitration
// between the two ports. When it is undefined, a data request that can be
// served always wins over an instruction request.
module mem_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_imem_ren,
   input  logic [31:0] i_imem_addr,
   output logic        o_imem_ready,
   output logic        o_imem_valid,
   output logic [31:0] o_imem_rdata,
   input  logic        i_dmem_ren,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_dmem_addr,
   input  logic [3:0]  i_dmem_mask,
   input  logic [31:0] i_dmem_wdata,
   output logic        o_dmem_ready,
   output logic        o_dmem_valid,
   output logic [31:0] o_dmem_rdata,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_mask,
   output logic [31:0] o_mem_wdata,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_rdata,
   output logic        o_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] tag_q;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             err_q, err_d;

   logic iq, dq, rd_ok, i_elig, d_elig;
   logic gnt_i, gnt_d, go, push, pop, cnt_nz, head;

   // Request qualification: reads need a free tag slot, writes never do.
   always_comb begin
      iq     = i_imem_ren;
      dq     = i_dmem_ren | i_dmem_wen;
      rd_ok  = (count_q != CNT_FULL);
      i_elig = iq & rd_ok;
      d_elig = i_dmem_wen | (i_dmem_ren & rd_ok);
      go     = i_mem_ready & ~i_rst;
   end

`ifdef MEM_ARBITER_RR_EN
   // 0 = imem was granted last, 1 = dmem was granted last.
   logic last_q, last_d;

   // Round-robin grant: on a tie, serve the port that was not served last.
   always_comb begin
      gnt_d  = d_elig & (~i_elig | ~last_q);
      gnt_i  = i_elig & ~gnt_d;
      last_d = last_q;
      if (o_imem_ready) begin
         last_d = 1'b0;
      end else if (o_dmem_ready) begin
         last_d = 1'b1;
      end
   end

   // Last-grant register moves only on an accepted transaction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q <= 1'b0;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority grant: an eligible data request always wins.
   always_comb begin
      gnt_d = d_elig;
      gnt_i = i_elig & ~d_elig;
   end
`endif

   // Memory request mux and per-port accept strobes.
   always_comb begin
      o_imem_ready = go & gnt_i;
      o_dmem_ready = go & gnt_d;
      o_mem_ren    = go & (gnt_i | (gnt_d & i_dmem_ren));
      o_mem_wen    = go & gnt_d & i_dmem_wen;
      o_mem_addr   = gnt_d ? i_dmem_addr  : i_imem_addr;
      o_mem_mask   = gnt_d ? i_dmem_mask  : 4'hF;
      o_mem_wdata  = gnt_d ? i_dmem_wdata : 32'h0;
   end

   // Response routing by the tag at the FIFO head.
   always_comb begin
      cnt_nz       = (count_q != '0);
      head         = tag_q[rptr_q];
      pop          = i_mem_valid & cnt_nz & ~i_rst;
      push         = o_mem_ren;
      o_imem_valid = pop & ~head;
      o_dmem_valid = pop & head;
      o_imem_rdata = i_mem_rdata;
      o_dmem_rdata = i_mem_rdata;
      o_err        = err_q;
   end

   // Next-state for FIFO pointers, occupancy and the sticky error flag.
   always_comb begin
      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      if (push & ~pop) begin
         count_d = count_q + 1'b1;
      end else if (pop & ~push) begin
         count_d = count_q - 1'b1;
      end
      err_d = err_q | (i_mem_valid & ~cnt_nz);
   end

   // Control state; reset discards every in-flight tag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Tag storage: 0 marks an imem read, 1 a dmem read.
   always_ff @(posedge i_clk) begin
      if (push) begin
         tag_q[wptr_q] <= gnt_d;
      end
   end

   // dq is folded into d_elig; kept for readability of the request terms.
   logic unused_dq;
   assign unused_dq = dq;

endmodule
